instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Sequences the core's instruction memory read port: owns the PC, drives the word address, captures the returned word with its PC into a small prefetch FIFO, and hands {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) and halt detection.
- Sits between the instruction memory (combinational read, RD = mem[A[31:2]]) and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.
- HALT_INSTR, 32'h0000_0073, encoding that stops fetching once accepted into the FIFO.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals pc; bits [1:0] always 0.
- imem_reset  out  1  copy of reset; forces memory RD to 0 during reset.
- imem_rdata  in  32  instruction word, valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, FIFO count=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Reset overrides every other input in the same cycle.
- States:
  - RUN: fetch enabled.
  - HALTED: fetch disabled, FIFO drains.
- Pop: when out_valid && out_ready at the clock edge.
- Push (RUN only): when count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle.
  - Writes {pc, imem_rdata} to the tail.
  - Updates pc <= pc+4; 32-bit wrap, so 0xFFFF_FFFC -> 0x0000_0000.
- Stall: FIFO full with no pop means no push, and pc holds.
- Throughput: one instruction per cycle when out_ready is held high.
- Latency: a word fetched in cycle N is visible on out_* in cycle N+1.
- Simultaneous push and pop keep count unchanged.
- Halt: if the pushed word equals HALT_INSTR, it is pushed, pc does not advance, and state moves to HALTED next cycle.
- Redirect (highest priority after reset):
  - Flushes all FIFO entries; out_valid=0 next cycle.
  - Suppresses this cycle's push and pop.
  - pc <= {redirect_pc[31:2],2'b00}; state <= RUN, including from HALTED.
  - First new instruction appears at out_* 2 cycles after the redirect cycle.
- out_* hold stable while out_valid && !out_ready.
- out_instr and out_pc values when out_valid=0 are don't-care; the bench must not check them.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two output ports, both reset to 0 and wrapping at 2^32:
  - perf_fetched (32): increments on every push.
  - perf_stall (32): increments each RUN cycle where the FIFO is full and there is no pop.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package fetch_pkg: state enum {RUN, HALTED}, default RESET_PC and HALT_INSTR constants, and the fetch-entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo:
  - Parameterised depth, synchronous flush.
  - Push, pop, full, empty, count.
  - Simultaneous push and pop allowed when full.

Test Plan:
- Reset release, memory words 0x0062E233, 0x00520533, 0x00A02023, out_ready=1 -> out_pc 0,4,8 on consecutive cycles, first valid one cycle after reset deasserts, out_instr matches.
- out_ready=0 for 5 cycles -> count reaches 2, imem_addr holds at 0x8, perf_stall=3 (macro on); then out_ready=1 -> PCs 0,4,8 with no gaps or duplicates.
- Redirect to 0x0000_0102 while FIFO is full -> out_valid=0 next cycle, imem_addr=0x100, out_pc=0x100 two cycles later.
- Memory word at 0x10 = 0x00000073 -> it is delivered, halted=1, imem_addr stays 0x10, and out_valid drops after drain; redirect to 0x0 -> halted=0 and fetch resumes.
- RESET_PC=0xFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with FIFO non-empty -> next cycle out_valid=0, pc=RESET_PC, counters=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; power-of-two depth, synchronous flush,
// accepts a push while full when the head is popped in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign head_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push_s && !do_pop_s)      count_q <= count_q + CW'(1);
      else if (do_pop_s && !do_push_s) count_q <= count_q - CW'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, prefetch FIFO, redirect and halt.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_reset,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         pop_s;
  logic         push_s;
  logic         halt_hit_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;

  // A redirect cancels both ends of the FIFO for the cycle it is seen.
  assign pop_s       = out_valid && out_ready && !redirect_valid;
  assign push_s      = (state_q == RUN) && !redirect_valid && (!fifo_full_s || pop_s);
  assign halt_hit_s  = push_s && (imem_rdata == HALT_INSTR);
  assign push_data_s = '{pc: pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_valid),
    .push_i     (push_s),
    .push_data_i(push_data_s),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s)
  );

  // Next PC and fetch state.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      state_d = RUN;
    end else if (halt_hit_s) begin
      state_d = HALTED;
    end else if (push_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= word_align(RESET_PC);
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_reset = reset;
  assign out_valid  = !fifo_empty_s;
  assign out_instr  = fifo_empty_s ? 32'h0000_0000 : head_s.instr;
  assign out_pc     = fifo_empty_s ? 32'h0000_0000 : head_s.pc;
  assign halted     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;
  logic        stall_s;

  assign stall_s = (state_q == RUN) && !redirect_valid && fifo_full_s && !pop_s;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (push_s)  perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall_s) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Table-driven bench for instr_fetch_ctrl plus a PC-wrap sequence on a second
// instance built with RESET_PC = 0xFFFF_FFF8.
module tb_instr_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic        exp_halted;
  } vec_t;

  localparam int NV = 25;
  localparam logic [31:0] W0 = 32'h0062_E233;
  localparam logic [31:0] W1 = 32'h0052_0533;
  localparam logic [31:0] W2 = 32'h00A0_2023;
  localparam logic [31:0] W3 = 32'h00B5_0593;
  localparam logic [31:0] WH = 32'h0000_0073;
  localparam logic [31:0] WA = 32'h1000_0113;
  localparam logic [31:0] WB = 32'h1040_0193;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_reset;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic        reset2 = 1'b1;
  logic [31:0] imem_addr2;
  logic        imem_reset2;
  logic [31:0] imem_rdata2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic        halted2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_fetched2;
  logic [31:0] perf_stall2;
`endif

  int   errors = 0;
  int   n_checks = 0;
  vec_t vec [NV];

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return W0;
      32'h0000_0004: return W1;
      32'h0000_0008: return W2;
      32'h0000_000C: return W3;
      32'h0000_0010: return WH;
      32'h0000_0100: return WA;
      32'h0000_0104: return WB;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign imem_rdata  = imem_reset  ? 32'h0 : memword(imem_addr);
  assign imem_rdata2 = imem_reset2 ? 32'h0 : memword(imem_addr2);

  instr_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_reset    (imem_reset),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  instr_fetch_ctrl #(
    .RESET_PC(32'hFFFF_FFF8)
  ) dut2 (
    .clk           (clk),
    .reset         (reset2),
    .imem_addr     (imem_addr2),
    .imem_reset    (imem_reset2),
    .imem_rdata    (imem_rdata2),
    .redirect_valid(redirect_valid2),
    .redirect_pc   (redirect_pc2),
    .out_valid     (out_valid2),
    .out_ready     (out_ready2),
    .out_instr     (out_instr2),
    .out_pc        (out_pc2),
    .halted        (halted2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched2),
    .perf_stall    (perf_stall2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //          rst   rv    rpc           rdy   valid pc            instr  addr          halted
    vec[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0, 32'h0000_0000, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, W0,   32'h0000_0004, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, W1,   32'h0000_0008, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, W2,   32'h0000_000C, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0, 32'h0000_0000, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, W0,   32'h0000_0004, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, W0,   32'h0000_0008, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, W0,   32'h0000_0008, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, W0,   32'h0000_0008, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, W0,   32'h0000_0008, 1'b0};
    vec[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, W1,   32'h0000_000C, 1'b0};
    vec[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, W2,   32'h0000_0010, 1'b0};
    vec[12] = '{1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0,       32'h0, 32'h0000_0100, 1'b0};
    vec[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, WA,   32'h0000_0104, 1'b0};
    vec[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0104, WB,   32'h0000_0108, 1'b0};
    vec[15] = '{1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0,       32'h0, 32'h0000_0008, 1'b0};
    vec[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, W2,   32'h0000_000C, 1'b0};
    vec[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, W3,   32'h0000_0010, 1'b0};
    vec[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0010, WH,   32'h0000_0010, 1'b1};
    vec[19] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, WH,   32'h0000_0010, 1'b1};
    vec[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0, 32'h0000_0010, 1'b1};
    vec[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0, 32'h0000_0010, 1'b1};
    vec[22] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,       32'h0, 32'h0000_0000, 1'b0};
    vec[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, W0,   32'h0000_0004, 1'b0};
    vec[24] = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0,       32'h0, 32'h0000_0000, 1'b0};

    for (int i = 0; i < NV; i++) begin
      reset          = vec[i].rst;
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      out_ready      = vec[i].rdy;
      #1;
      check($sformatf("row%0d imem_reset", i), {31'd0, imem_reset}, {31'd0, vec[i].rst});
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].exp_valid});
      check($sformatf("row%0d imem_addr", i), imem_addr, vec[i].exp_addr);
      check($sformatf("row%0d halted", i), {31'd0, halted}, {31'd0, vec[i].exp_halted});
      if (vec[i].exp_valid) begin
        check($sformatf("row%0d out_pc", i), out_pc, vec[i].exp_pc);
        check($sformatf("row%0d out_instr", i), out_instr, vec[i].exp_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 9) begin
        check("perf_fetched after stall", perf_fetched, 32'd2);
        check("perf_stall after stall", perf_stall, 32'd3);
      end
      if (i == 24) begin
        check("perf_fetched after reset", perf_fetched, 32'd0);
        check("perf_stall after reset", perf_stall, 32'd0);
      end
`endif
    end

    // PC wrap on the second instance.
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    check("wrap reset addr", imem_addr2, 32'hFFFF_FFF8);
    check("wrap reset valid", {31'd0, out_valid2}, 32'd0);
    reset2 = 1'b0;
    @(posedge clk);
    #1;
    check("wrap pc0", out_pc2, 32'hFFFF_FFF8);
    check("wrap instr0", out_instr2, 32'h3F21_FFF8);
    @(posedge clk);
    #1;
    check("wrap pc1", out_pc2, 32'hFFFF_FFFC);
    check("wrap instr1", out_instr2, 32'h3F21_FFFC);
    @(posedge clk);
    #1;
    check("wrap pc2", out_pc2, 32'h0000_0000);
    check("wrap instr2", out_instr2, W0);
    check("wrap addr2", imem_addr2, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
